// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 constants, FSM state types and small decode helpers for axi_slave_ram.
// Contents:
//   AXI_BURST_FIXED/INCR/WRAP : AxBURST encodings
//   AXI_RESP_OKAY/SLVERR      : xRESP encodings
//   w_state_e / r_state_e     : write and read channel FSM states
//   burst_is_err()            : flags burst types the slave serves as INCR but answers SLVERR
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

  // WRAP and the reserved encoding are walked like INCR but the burst must report SLVERR.
  function automatic logic burst_is_err(input logic [1:0] burst);
    return (burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_ram_core.sv
// axi_ram_core: word-addressed storage behind axi_slave_ram.
// One synchronous write port with per-byte enables, one asynchronous read port. A read and
// a write to the same word in the same cycle return the old contents. No reset: contents
// are undefined after power-up or reset.
// Ports:
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_wbe    : write byte enables (one per data byte)
//   i_raddr  : read word index
//   o_rdata  : read data (combinational from i_raddr)
module axi_ram_core #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 1024,
  localparam int unsigned NumBytes = DataWidth / 8,
  localparam int unsigned AddrW    = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AddrW-1:0]     i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [NumBytes-1:0]  i_wbe,
  input  logic [AddrW-1:0]     i_raddr,
  output logic [DataWidth-1:0] o_rdata
);

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave in front of an on-chip word RAM.
// Independent write (AW/W/B) and read (AR/R) state machines, one outstanding burst each.
// INCR and FIXED bursts are served; WRAP/reserved are walked as INCR and answer SLVERR.
// Wrong beat size, out-of-range beats and misplaced wlast also answer SLVERR; erroneous
// write beats are dropped and erroneous read beats return zero data.
// Build option: define AXI_SLAVE_RAM_WSTRB_EN to honour s_axi_wstrb; otherwise every accepted
// beat writes the whole word.
// Ports:
//   s_axi_aclk, s_axi_aresetn      : clock, asynchronous active-low reset
//   s_axi_aw*                      : write address channel (id, addr, len, size, burst)
//   s_axi_w*                       : write data channel (data, strb, last)
//   s_axi_b*                       : write response channel (id, resp)
//   s_axi_ar*                      : read address channel (id, addr, len, size, burst)
//   s_axi_r*                       : read data channel (id, data, resp, last)
module axi_slave_ram
  import axi_pkg::*;
#(
  parameter int unsigned S_AXI_ID_WIDTH   = 1,
  parameter int unsigned S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned S_AXI_DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH        = 1024,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] S_SLAVE_BASE_ADDR = 32'h4000_0000
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int unsigned NumBytes  = S_AXI_DATA_WIDTH / 8;
  localparam int unsigned AddrShift = $clog2(NumBytes);
  localparam int unsigned RamAw     = $clog2(RAM_DEPTH);
  localparam logic [2:0]  BeatSize  = 3'(AddrShift);
  localparam logic [S_AXI_ADDR_WIDTH-1:0] DepthLimit = S_AXI_ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [S_AXI_ADDR_WIDTH-1:0] IdxOne     = S_AXI_ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------------------------
  // Address decode. Indices are kept at full address width so an INCR burst that walks past
  // the top of the RAM stays out of range instead of wrapping back to word 0.
  // ---------------------------------------------------------------------------------------
  logic [S_AXI_ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
  logic                        w_aw_below, w_ar_below;

  assign w_aw_below = s_axi_awaddr < S_SLAVE_BASE_ADDR;
  assign w_ar_below = s_axi_araddr < S_SLAVE_BASE_ADDR;
  assign w_aw_idx   = (s_axi_awaddr - S_SLAVE_BASE_ADDR) >> AddrShift;
  assign w_ar_idx   = (s_axi_araddr - S_SLAVE_BASE_ADDR) >> AddrShift;

  // ---------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------
  w_state_e                    r_wstate;
  logic                        r_awready, r_wready, r_bvalid;
  logic [1:0]                  r_bresp;
  logic [S_AXI_ID_WIDTH-1:0]   r_bid;
  logic [S_AXI_ADDR_WIDTH-1:0] r_widx;
  logic [7:0]                  r_w_len, r_w_beat;
  logic                        r_w_fixed, r_w_below, r_w_size_err, r_w_over, r_w_err;

  logic                        w_w_hs, w_w_oor, w_wr_en, w_w_beat_err;
  logic [NumBytes-1:0]         w_wbe;

  assign w_w_hs  = s_axi_wvalid && r_wready;
  assign w_w_oor = r_w_below || (r_widx >= DepthLimit);
  // r_w_over marks beats past awlen+1: they are absorbed until wlast but never written.
  assign w_wr_en = w_w_hs && !w_w_oor && !r_w_size_err && !r_w_over;
  // A wlast anywhere other than beat awlen (or after overrun) poisons the response.
  assign w_w_beat_err = w_w_oor || (s_axi_wlast && (r_w_over || (r_w_beat != r_w_len)));

`ifdef AXI_SLAVE_RAM_WSTRB_EN
  assign w_wbe = s_axi_wstrb;
`else
  assign w_wbe = '1;
  logic w_unused_wstrb;
  assign w_unused_wstrb = ^s_axi_wstrb;
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wstate     <= WIdle;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= AXI_RESP_OKAY;
      r_bid        <= '0;
      r_widx       <= '0;
      r_w_len      <= '0;
      r_w_beat     <= '0;
      r_w_fixed    <= 1'b0;
      r_w_below    <= 1'b0;
      r_w_size_err <= 1'b0;
      r_w_over     <= 1'b0;
      r_w_err      <= 1'b0;
    end else begin
      unique case (r_wstate)
        WIdle: begin
          r_awready <= 1'b1;
          if (s_axi_awvalid && r_awready) begin
            r_awready    <= 1'b0;
            r_wready     <= 1'b1;
            r_bid        <= s_axi_awid;
            r_widx       <= w_aw_idx;
            r_w_len      <= s_axi_awlen;
            r_w_beat     <= '0;
            r_w_fixed    <= (s_axi_awburst == AXI_BURST_FIXED);
            r_w_below    <= w_aw_below;
            r_w_size_err <= (s_axi_awsize != BeatSize);
            r_w_over     <= 1'b0;
            r_w_err      <= (s_axi_awsize != BeatSize) || burst_is_err(s_axi_awburst);
            r_wstate     <= WData;
          end
        end
        WData: begin
          if (w_w_hs) begin
            if (!r_w_fixed) begin
              r_widx <= r_widx + IdxOne;
            end
            if (s_axi_wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_w_err || w_w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              r_wstate <= WResp;
            end else begin
              if (r_w_beat == r_w_len) begin
                r_w_over <= 1'b1;
              end else begin
                r_w_beat <= r_w_beat + 8'd1;
              end
              r_w_err <= r_w_err || w_w_beat_err;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= WIdle;
          end
        end
        default: r_wstate <= WIdle;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;

  // ---------------------------------------------------------------------------------------
  // Read channel. r_ridx always points at the word for the *next* beat, so the async RAM
  // port can prefetch it while the current beat sits in the output registers.
  // ---------------------------------------------------------------------------------------
  r_state_e                    r_rstate;
  logic                        r_arready, r_rvalid, r_rlast;
  logic [1:0]                  r_rresp;
  logic [S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [S_AXI_ID_WIDTH-1:0]   r_rid;
  logic [S_AXI_ADDR_WIDTH-1:0] r_ridx;
  logic [7:0]                  r_r_len, r_r_cnt;
  logic                        r_r_fixed, r_r_below, r_r_size_err, r_r_burst_err;

  logic [S_AXI_ADDR_WIDTH-1:0] w_rd_idx;
  logic                        w_rd_below, w_rd_size_err, w_rd_burst_err, w_rd_oor;
  logic [S_AXI_DATA_WIDTH-1:0] w_ram_rdata, w_rd_data;
  logic [1:0]                  w_rd_resp;

  // In RIdle the beat being looked up is beat 0 of the burst presented on AR.
  always_comb begin
    w_rd_idx       = r_ridx;
    w_rd_below     = r_r_below;
    w_rd_size_err  = r_r_size_err;
    w_rd_burst_err = r_r_burst_err;
    if (r_rstate == RIdle) begin
      w_rd_idx       = w_ar_idx;
      w_rd_below     = w_ar_below;
      w_rd_size_err  = (s_axi_arsize != BeatSize);
      w_rd_burst_err = burst_is_err(s_axi_arburst);
    end
    w_rd_oor  = w_rd_below || (w_rd_idx >= DepthLimit);
    w_rd_data = (w_rd_oor || w_rd_size_err) ? '0 : w_ram_rdata;
    w_rd_resp = (w_rd_oor || w_rd_size_err || w_rd_burst_err) ? AXI_RESP_SLVERR
                                                               : AXI_RESP_OKAY;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rstate      <= RIdle;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rlast       <= 1'b0;
      r_rresp       <= AXI_RESP_OKAY;
      r_rdata       <= '0;
      r_rid         <= '0;
      r_ridx        <= '0;
      r_r_len       <= '0;
      r_r_cnt       <= '0;
      r_r_fixed     <= 1'b0;
      r_r_below     <= 1'b0;
      r_r_size_err  <= 1'b0;
      r_r_burst_err <= 1'b0;
    end else begin
      unique case (r_rstate)
        RIdle: begin
          r_arready <= 1'b1;
          if (s_axi_arvalid && r_arready) begin
            r_arready     <= 1'b0;
            r_rvalid      <= 1'b1;
            r_rid         <= s_axi_arid;
            r_rdata       <= w_rd_data;
            r_rresp       <= w_rd_resp;
            r_rlast       <= (s_axi_arlen == 8'd0);
            r_r_len       <= s_axi_arlen;
            r_r_cnt       <= '0;
            r_r_fixed     <= (s_axi_arburst == AXI_BURST_FIXED);
            r_r_below     <= w_ar_below;
            r_r_size_err  <= w_rd_size_err;
            r_r_burst_err <= w_rd_burst_err;
            r_ridx        <= (s_axi_arburst == AXI_BURST_FIXED) ? w_ar_idx : w_ar_idx + IdxOne;
            r_rstate      <= RData;
          end
        end
        RData: begin
          // Output registers only move on a handshake, so a stalled beat holds steady.
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= RIdle;
            end else begin
              r_r_cnt <= r_r_cnt + 8'd1;
              r_rdata <= w_rd_data;
              r_rresp <= w_rd_resp;
              r_rlast <= ((r_r_cnt + 8'd1) == r_r_len);
              if (!r_r_fixed) begin
                r_ridx <= r_ridx + IdxOne;
              end
            end
          end
        end
        default: r_rstate <= RIdle;
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_rid;

  // ---------------------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------------------
  axi_ram_core #(
    .DataWidth (S_AXI_DATA_WIDTH),
    .Depth     (RAM_DEPTH)
  ) u_ram_core (
    .i_clk   (s_axi_aclk),
    .i_we    (w_wr_en),
    .i_waddr (r_widx[RamAw-1:0]),
    .i_wdata (s_axi_wdata),
    .i_wbe   (w_wbe),
    .i_raddr (w_rd_idx[RamAw-1:0]),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed, self-checking bench for axi_slave_ram (default parameters).
module tb_axi_slave_ram;

  localparam int Tmo = 200;
`ifdef AXI_SLAVE_RAM_WSTRB_EN
  localparam bit StrbEn = 1'b1;
`else
  localparam bit StrbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_slave_ram #(
    .S_AXI_ID_WIDTH    (1),
    .S_AXI_ADDR_WIDTH  (32),
    .S_AXI_DATA_WIDTH  (32),
    .RAM_DEPTH         (1024),
    .S_SLAVE_BASE_ADDR (32'h4000_0000)
  ) u_dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] wbuf [32];
  logic [31:0] rbuf [32];
  logic [1:0]  rresp_buf [32];
  logic        rlast_buf [32];
  int          rcount;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL timeout_%s: no handshake within %0d cycles, expected one", name, Tmo);
  endtask

  // All tasks start and end just after a falling edge; registered DUT outputs are stable there.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                          input int nbeats, input int last_beat, output logic [1:0] resp);
    int t;
    resp = 2'bxx;
    s_axi_awid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < Tmo) begin @(negedge clk); t++; end
    if (t >= Tmo) begin s_axi_awvalid = 1'b0; timeout("aw"); return; end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check("wready_after_aw", s_axi_wready, 1);
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wdata = wbuf[i]; s_axi_wstrb = strb; s_axi_wlast = (i == last_beat);
      s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < Tmo) begin @(negedge clk); t++; end
      if (t >= Tmo) begin s_axi_wvalid = 1'b0; timeout("w"); return; end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid_after_wlast", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < Tmo) begin @(negedge clk); t++; end
    if (t >= Tmo) begin s_axi_bready = 1'b0; timeout("b"); return; end
    resp = s_axi_bresp;
    check("bid", s_axi_bid, 1);
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("awready_after_b", s_axi_awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input bit toggle);
    int t;
    bit done, stalled;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    rcount = 0; done = 0; stalled = 0; h_data = '0; h_resp = '0; h_last = 1'b0;
    s_axi_arid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < Tmo) begin @(negedge clk); t++; end
    if (t >= Tmo) begin s_axi_arvalid = 1'b0; timeout("ar"); return; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("rvalid_after_ar", s_axi_rvalid, 1);
    t = 0;
    while (!done && t < Tmo) begin
      s_axi_rready = toggle ? ((t % 2) == 0) : 1'b1;
      if (s_axi_rvalid) begin
        if (stalled) begin
          check("rdata_stable", s_axi_rdata, h_data);
          check("rresp_stable", s_axi_rresp, h_resp);
          check("rlast_stable", s_axi_rlast, h_last);
        end
        if (s_axi_rready) begin
          if (rcount < 32) begin
            rbuf[rcount] = s_axi_rdata;
            rresp_buf[rcount] = s_axi_rresp;
            rlast_buf[rcount] = s_axi_rlast;
          end
          rcount++;
          done = s_axi_rlast;
          stalled = 0;
          check("rid", s_axi_rid, 1);
        end else begin
          stalled = 1; h_data = s_axi_rdata; h_resp = s_axi_rresp; h_last = s_axi_rlast;
        end
      end
      @(negedge clk);
      t++;
    end
    s_axi_rready = 1'b0;
    if (!done) begin
      timeout("rlast");
    end else begin
      check("read_beat_count", 32'(rcount), 32'(len) + 32'd1);
      check("arready_after_rlast", s_axi_arready, 1);
    end
  endtask

  logic [1:0] resp;

  initial begin
    vecs[0] = '{32'h4000_0100, 32'h0, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h4000_0104, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0011, 2'b00,
                StrbEn ? 32'h1234_FFFF : 32'hFFFF_FFFF, 2'b00};
    vecs[2] = '{32'h4000_0108, 32'hAABB_CCDD, 32'h1122_3344, 4'b1000, 2'b00,
                StrbEn ? 32'h11BB_CCDD : 32'h1122_3344, 2'b00};
    vecs[3] = '{32'h4000_0110, 32'h5555_5555, 32'h0, 4'b0000, 2'b00,
                StrbEn ? 32'h5555_5555 : 32'h0, 2'b00};
    vecs[4] = '{32'h4000_0FFC, 32'h0, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[5] = '{32'h4000_1000, 32'h0, 32'h6666_6666, 4'hF, 2'b10, 32'h0, 2'b10};
    vecs[6] = '{32'h3FFF_FFFC, 32'h0, 32'h7777_7777, 4'hF, 2'b10, 32'h0, 2'b10};
    vecs[7] = '{32'h4000_0000, 32'h0, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};

    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_ctrl_outputs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
          s_axi_bid, s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid}, 0);
    check("reset_rdata", s_axi_rdata, 0);
    rst_n = 1'b1;
    check("awready_before_first_clk", s_axi_awready, 0);
    @(negedge clk);
    check("awready_after_reset", s_axi_awready, 1);
    check("arready_after_reset", s_axi_arready, 1);

    // wvalid ahead of AW must not be accepted
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wdata = 32'h5A5A_5A5A;
    for (int i = 0; i < 3; i++) begin
      check("wready_low_in_idle", s_axi_wready, 0);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

    // Single-beat vectors
    for (int v = 0; v < 8; v++) begin
      wbuf[0] = vecs[v].pre;
      do_write(vecs[v].addr, 8'd0, 2'b01, 3'd2, 4'hF, 1, 0, resp);
      check($sformatf("vec%0d_pre_bresp", v), resp, vecs[v].exp_bresp);
      wbuf[0] = vecs[v].wdata;
      do_write(vecs[v].addr, 8'd0, 2'b01, 3'd2, vecs[v].strb, 1, 0, resp);
      check($sformatf("vec%0d_bresp", v), resp, vecs[v].exp_bresp);
      do_read(vecs[v].addr, 8'd0, 2'b01, 3'd2, 1'b0);
      check($sformatf("vec%0d_rdata", v), rbuf[0], vecs[v].exp_rdata);
      check($sformatf("vec%0d_rresp", v), rresp_buf[0], vecs[v].exp_rresp);
      check($sformatf("vec%0d_rlast", v), rlast_buf[0], 1);
    end

    // INCR 16-beat write/read at 0x4000_0004 (words 1..16)
    for (int i = 0; i < 16; i++) wbuf[i] = 32'(i + 1);
    do_write(32'h4000_0004, 8'd15, 2'b01, 3'd2, 4'hF, 16, 15, resp);
    check("incr16_bresp", resp, 2'b00);
    do_read(32'h4000_0004, 8'd15, 2'b01, 3'd2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("incr16_rdata%0d", i), rbuf[i], 32'(i + 1));
      check($sformatf("incr16_rresp%0d", i), rresp_buf[i], 2'b00);
      check($sformatf("incr16_rlast%0d", i), rlast_buf[i], (i == 15));
    end

    // FIXED read repeats one word
    do_read(32'h4000_0008, 8'd2, 2'b00, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) check("fixed_read", rbuf[i], 32'd2);

    // FIXED 4-beat write lands every beat on word 4; word 5 untouched
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    do_write(32'h4000_0010, 8'd3, 2'b00, 3'd2, 4'hF, 4, 3, resp);
    check("fixed_bresp", resp, 2'b00);
    do_read(32'h4000_0010, 8'd0, 2'b01, 3'd2, 1'b0);
    check("fixed_rdata", rbuf[0], 32'hD);
    do_read(32'h4000_0014, 8'd0, 2'b01, 3'd2, 1'b0);
    check("fixed_neighbour", rbuf[0], 32'd5);

    // Read backpressure with rready 1-0-1-0
    do_read(32'h4000_0004, 8'd3, 2'b01, 3'd2, 1'b1);
    check("bp_beat0", rbuf[0], 32'd1);
    check("bp_beat1", rbuf[1], 32'd2);
    check("bp_beat2", rbuf[2], 32'd3);
    check("bp_beat3", rbuf[3], 32'hD);

    // INCR write crossing the top of the RAM: no wrap to word 0
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    do_write(32'h4000_0FFC, 8'd1, 2'b01, 3'd2, 4'hF, 2, 1, resp);
    check("oor_write_bresp", resp, 2'b10);
    do_read(32'h4000_0FFC, 8'd1, 2'b01, 3'd2, 1'b0);
    check("oor_last_word", rbuf[0], 32'h77);
    check("oor_last_resp", rresp_buf[0], 2'b00);
    check("oor_cross_data", rbuf[1], 32'h0);
    check("oor_cross_resp", rresp_buf[1], 2'b10);
    do_read(32'h4000_0000, 8'd0, 2'b01, 3'd2, 1'b0);
    check("oor_word0_intact", rbuf[0], 32'h1);

    // Early wlast: awlen=3, wlast on the second beat
    wbuf[0] = 32'h1111; wbuf[1] = 32'h2222;
    do_write(32'h4000_0180, 8'd3, 2'b01, 3'd2, 4'hF, 2, 1, resp);
    check("early_wlast_bresp", resp, 2'b10);

    // Late wlast: awlen=1 but three beats; third is dropped
    wbuf[0] = 32'h0BAD;
    do_write(32'h4000_0208, 8'd0, 2'b01, 3'd2, 4'hF, 1, 0, resp);
    wbuf[0] = 32'hF00; wbuf[1] = 32'hF01; wbuf[2] = 32'hF02;
    do_write(32'h4000_0200, 8'd1, 2'b01, 3'd2, 4'hF, 3, 2, resp);
    check("late_wlast_bresp", resp, 2'b10);
    do_read(32'h4000_0200, 8'd2, 2'b01, 3'd2, 1'b0);
    check("late_beat0", rbuf[0], 32'hF00);
    check("late_beat1", rbuf[1], 32'hF01);
    check("late_dropped", rbuf[2], 32'h0BAD);

    // Wrong beat size: write dropped, read returns zero with SLVERR
    wbuf[0] = 32'h3333_3333;
    do_write(32'h4000_0300, 8'd0, 2'b01, 3'd2, 4'hF, 1, 0, resp);
    wbuf[0] = 32'hEEEE_EEEE;
    do_write(32'h4000_0300, 8'd0, 2'b01, 3'd1, 4'hF, 1, 0, resp);
    check("size_err_bresp", resp, 2'b10);
    do_read(32'h4000_0300, 8'd0, 2'b01, 3'd2, 1'b0);
    check("size_err_write_dropped", rbuf[0], 32'h3333_3333);
    do_read(32'h4000_0300, 8'd0, 2'b01, 3'd1, 1'b0);
    check("size_err_rdata", rbuf[0], 32'h0);
    check("size_err_rresp", rresp_buf[0], 2'b10);

    // WRAP burst is walked as INCR but answers SLVERR
    wbuf[0] = 32'hA1; wbuf[1] = 32'hA2;
    do_write(32'h4000_0400, 8'd1, 2'b10, 3'd2, 4'hF, 2, 1, resp);
    check("wrap_bresp", resp, 2'b10);
    do_read(32'h4000_0400, 8'd1, 2'b01, 3'd2, 1'b0);
    check("wrap_data0", rbuf[0], 32'hA1);
    check("wrap_data1", rbuf[1], 32'hA2);
    do_read(32'h4000_0400, 8'd1, 2'b10, 3'd2, 1'b0);
    check("wrap_read_data1", rbuf[1], 32'hA2);
    check("wrap_read_resp", rresp_buf[1], 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
